mdu_status_wb: RTL and testbench

- Buffered status-writeback stage for the multi-cycle multiply/divide unit.
- Accepts completed MDU status records (overflow flag, LT/GT/EQ compare bits, OE/Rc flags, target CR field) through a valid/ready handshake.
- Queues records in a small FIFO and commits one per cycle to XER (OV, SO) and to a selectable CR field.
- Keeps an internal bypass of the last written XER value, so back-to-back commits see correct sticky SO before the architectural register updates.

---
 rtl/mdu_status_wb_pkg.sv | 29 ++
 rtl/mdu_status_fifo.sv | 58 +++++
 rtl/mdu_status_wb.sv | 116 +++++++++++
 tb/tb_mdu_status_wb.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_status_wb_pkg.sv
// rtl/mdu_status_wb_pkg.sv - shared codes, record layout and XER/CR bit positions for MDU status writeback
package mdu_status_wb_pkg;

    localparam int MDU_OP_W   = 2;
    localparam int CR_FIELD_W = 4;

    // XER bit positions (LSB-0 numbering of the architectural register)
    localparam int XER_SO = 31;
    localparam int XER_OV = 30;

    typedef enum logic [MDU_OP_W-1:0] {
        MDU_OP_NOP = 2'd0,
        MDU_OP_OV  = 2'd1
    } mdu_dout_op_e;

    typedef struct packed {
        logic [MDU_OP_W-1:0] op;
        logic                oe;
        logic                rc;
        logic                ov;
        logic [2:0]          cr3;
    } mdu_rec_t;

    // CR field bits are big-endian: LT lands in the lowest bit of the field, SO in the highest.
    function automatic logic [CR_FIELD_W-1:0] cr_field_bits(input logic [2:0] cr3, input logic so);
        return {so, cr3[0], cr3[1], cr3[2]};
    endfunction

endpackage

// File: rtl/mdu_status_fifo.sv
// rtl/mdu_status_fifo.sv - DEPTH-entry circular buffer for queued MDU status records
module mdu_status_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign rdata   = mem[rptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage has no reset: entries are only ever read behind a valid count.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/mdu_status_wb.sv
// rtl/mdu_status_wb.sv - buffered MDU status writeback to XER (OV/SO) and a selectable CR field
module mdu_status_wb
    import mdu_status_wb_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int CR_FIELDS = 8,
    parameter int XER_W     = 32,
    parameter int CRF_W     = $clog2(CR_FIELDS)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [MDU_OP_W-1:0]            in_op,
    input  logic                           in_oe,
    input  logic                           in_rc,
    input  logic                           in_ov,
    input  logic [2:0]                     in_cr3,
    input  logic [CRF_W-1:0]               in_crf,
    input  logic                           flush,
    input  logic                           wb_en,
    input  logic [XER_W-1:0]               xer_rd,
    input  logic [CR_FIELD_W*CR_FIELDS-1:0] cr_rd,
    output logic                           xer_we,
    output logic [XER_W-1:0]               xer_wd,
    output logic                           cr_we,
    output logic [CR_FIELD_W*CR_FIELDS-1:0] cr_wd,
    output logic                           busy
);

    localparam int CR_W  = CR_FIELD_W * CR_FIELDS;
    localparam int REC_W = $bits(mdu_rec_t) + CRF_W;

    mdu_rec_t          in_rec;
    mdu_rec_t          head_rec;
    logic [CRF_W-1:0]  head_crf;
    logic [REC_W-1:0]  head_data;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop_go;
    logic              ov_upd;
    logic              crf_ok;
    logic [XER_W-1:0]  eff_xer;
    logic [XER_W-1:0]  xer_next;
    logic [CR_W-1:0]   cr_next;
    logic              bypass_v;
    logic [XER_W-1:0]  bypass_xer;
    logic [1:0]        bypass_age;

    assign in_rec = {in_op, in_oe, in_rc, in_ov, in_cr3};

    mdu_status_fifo #(
        .DEPTH (DEPTH),
        .W     (REC_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_valid),
        .pop   (wb_en),
        .flush (flush),
        .wdata ({in_rec, in_crf}),
        .rdata (head_data),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign {head_rec, head_crf} = head_data;
    assign in_ready = !fifo_full;
    assign pop_go   = wb_en && !fifo_empty && !flush;
    assign ov_upd   = (head_rec.op == MDU_OP_OV) && head_rec.oe;
    assign crf_ok   = (32'(head_crf) < CR_FIELDS);
    assign busy     = !fifo_empty || xer_we || cr_we;

    always_comb begin
        eff_xer  = bypass_v ? bypass_xer : xer_rd;
        xer_next = eff_xer;
        if (ov_upd) begin
            xer_next[XER_OV] = head_rec.ov;
            xer_next[XER_SO] = head_rec.ov | eff_xer[XER_SO];
        end
        cr_next = cr_rd;
        for (int f = 0; f < CR_FIELDS; f++) begin
            if (crf_ok && (head_crf == CRF_W'(f)))
                cr_next[f*CR_FIELD_W +: CR_FIELD_W] = cr_field_bits(head_rec.cr3, xer_next[XER_SO]);
        end
    end

    // The bypass covers the window until the architectural XER has absorbed our last write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xer_we     <= 1'b0;
            cr_we      <= 1'b0;
            xer_wd     <= '0;
            cr_wd      <= '0;
            bypass_v   <= 1'b0;
            bypass_xer <= '0;
            bypass_age <= '0;
        end else begin
            xer_we <= pop_go && ov_upd;
            cr_we  <= pop_go && head_rec.rc && crf_ok;
            if (pop_go) begin
                xer_wd <= xer_next;
                cr_wd  <= cr_next;
            end
            if (pop_go && ov_upd) begin
                bypass_xer <= xer_next;
                bypass_v   <= 1'b1;
                bypass_age <= 2'd0;
            end else if (bypass_v) begin
                if (bypass_age == 2'd1) bypass_v <= 1'b0;
                else                    bypass_age <= bypass_age + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_mdu_status_wb.sv
// tb/tb_mdu_status_wb.sv - self-checking bench for mdu_status_wb with an in-bench record-level model
module tb_mdu_status_wb;

    typedef struct {
        logic [1:0] op;
        logic       oe;
        logic       rc;
        logic       ov;
        logic [2:0] cr3;
        logic [2:0] crf;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_valid1;
    logic [1:0]  in_op;
    logic        in_oe, in_rc, in_ov;
    logic [2:0]  in_cr3, in_crf;
    logic        flush, wb_en;
    logic [31:0] xer_arch;
    logic [31:0] cr_rd;
    logic        in_ready, xer_we, cr_we, busy;
    logic [31:0] xer_wd, cr_wd;
    logic        in_ready1, xer_we1, cr_we1, busy1;
    logic [31:0] xer_wd1;
    logic [15:0] cr_wd1;

    int n_chk = 0;
    int n_fail = 0;

    rec_t        mq[$];
    logic [31:0] m_xer;
    logic        exp_wr, exp_xwe, exp_cwe;
    logic [31:0] exp_xwd, exp_cwd;

    mdu_status_wb #(.DEPTH(4), .CR_FIELDS(8), .XER_W(32), .CRF_W(3)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_oe(in_oe), .in_rc(in_rc), .in_ov(in_ov),
        .in_cr3(in_cr3), .in_crf(in_crf), .flush(flush), .wb_en(wb_en),
        .xer_rd(xer_arch), .cr_rd(cr_rd), .xer_we(xer_we), .xer_wd(xer_wd),
        .cr_we(cr_we), .cr_wd(cr_wd), .busy(busy)
    );

    mdu_status_wb #(.DEPTH(2), .CR_FIELDS(4), .XER_W(32), .CRF_W(3)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .in_op(in_op), .in_oe(in_oe), .in_rc(in_rc), .in_ov(in_ov),
        .in_cr3(in_cr3), .in_crf(in_crf), .flush(flush), .wb_en(wb_en),
        .xer_rd(xer_arch), .cr_rd(cr_rd[15:0]), .xer_we(xer_we1), .xer_wd(xer_wd1),
        .cr_we(cr_we1), .cr_wd(cr_wd1), .busy(busy1)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic set_rec(input logic [1:0] op, input logic oe, input logic rc,
                           input logic ov, input logic [2:0] cr3, input logic [2:0] crf);
        in_op = op; in_oe = oe; in_rc = rc; in_ov = ov; in_cr3 = cr3; in_crf = crf;
    endtask

    task automatic count_wr(input int cycles, output int n);
        n = 0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (xer_we || cr_we) n++;
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic set_arch(input logic [31:0] xv, input logic [31:0] cv);
        xer_arch = xv;
        m_xer    = xv;
        cr_rd    = cv;
    endtask

    // Record-level model: queue of accepted records; XER is the in-order fold of every committed record.
    task automatic model_loop();
        rec_t r;
        rec_t cur;
        logic take;
        logic upd;
        int   f;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                mq.delete();
                exp_wr = 0; exp_xwe = 0; exp_cwe = 0;
                m_xer = xer_arch;
            end else begin
                cur = '{op: in_op, oe: in_oe, rc: in_rc, ov: in_ov, cr3: in_cr3, crf: in_crf};
                take = in_valid && (mq.size() < 4) && !flush;
                if (xer_we) xer_arch <= xer_wd;
                exp_wr = 0; exp_xwe = 0; exp_cwe = 0;
                if (flush) begin
                    mq.delete();
                end else if (wb_en && mq.size() > 0) begin
                    r = mq.pop_front();
                    upd = (r.op == 2'd1) && r.oe;
                    if (upd) begin
                        m_xer[30] = r.ov;
                        m_xer[31] = m_xer[31] | r.ov;
                    end
                    f = int'(r.crf);
                    exp_xwe = upd;
                    exp_cwe = r.rc;
                    exp_xwd = m_xer;
                    exp_cwd = cr_rd;
                    exp_cwd[4*f]   = r.cr3[2];
                    exp_cwd[4*f+1] = r.cr3[1];
                    exp_cwd[4*f+2] = r.cr3[0];
                    exp_cwd[4*f+3] = m_xer[31];
                    exp_wr = upd || r.rc;
                end
                if (take) mq.push_back(cur);
            end
        end
    endtask

    task automatic compare_loop();
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("in_ready", in_ready, mq.size() < 4);
                chk("busy", busy, (mq.size() > 0) || exp_wr);
                chk("xer_we", xer_we, exp_xwe);
                chk("cr_we", cr_we, exp_cwe);
                if (exp_xwe) chk("xer_wd", xer_wd, exp_xwd);
                if (exp_cwe) chk("cr_wd", cr_wd, exp_cwd);
            end
        end
    endtask

    initial begin
        int n;
        rst = 1'b1; in_valid = 0; in_valid1 = 0; flush = 0; wb_en = 1;
        set_rec(0, 0, 0, 0, 0, 0);
        xer_arch = 0; m_xer = 0; cr_rd = 0;
        exp_wr = 0; exp_xwe = 0; exp_cwe = 0; exp_xwd = 0; exp_cwd = 0;
        fork
            model_loop();
            compare_loop();
        join_none
        #1;
        chk("rst0_in_ready", in_ready, 1);
        chk("rst0_busy", busy, 0);
        chk("rst0_xer_we", xer_we, 0);
        chk("rst0_cr_we", cr_we, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // basic commit and two-cycle push-to-write latency
        set_arch(32'h2000_0005, 32'h1234_5670);
        @(negedge clk); set_rec(1, 1, 1, 1, 3'b100, 0); in_valid = 1;
        @(negedge clk); in_valid = 0; chk("t1_latency_xer_we", xer_we, 0);
        @(negedge clk);
        chk("t1_xer_we", xer_we, 1);
        chk("t1_xer_wd", xer_wd, 32'hE000_0005);
        chk("t1_cr_we", cr_we, 1);
        chk("t1_cr_wd", cr_wd, 32'h1234_5679);

        // back-to-back commits must see sticky SO through the bypass
        idle(4);
        set_arch(32'h2000_0000, 32'h0);
        @(negedge clk); set_rec(1, 1, 0, 1, 3'b000, 0); in_valid = 1;
        @(negedge clk); set_rec(1, 1, 1, 0, 3'b010, 2);
        @(negedge clk); in_valid = 0;
        chk("t2a_xer_wd", xer_wd, 32'hE000_0000);
        @(negedge clk);
        chk("t2b_xer_we", xer_we, 1);
        chk("t2b_xer_wd", xer_wd, 32'hA000_0000);
        chk("t2b_cr_wd", cr_wd, 32'h0000_0A00);

        // oe=0: no XER write, CR SO from architectural XER
        idle(4);
        set_arch(32'h0, 32'h0);
        @(negedge clk); set_rec(1, 0, 1, 1, 3'b001, 1); in_valid = 1;
        @(negedge clk); in_valid = 0;
        @(negedge clk);
        chk("t3_xer_we", xer_we, 0);
        chk("t3_cr_we", cr_we, 1);
        chk("t3_cr_wd", cr_wd, 32'h0000_0040);

        // asynchronous reset with records queued
        idle(2); wb_en = 0;
        @(negedge clk); set_rec(1, 1, 1, 1, 3'b100, 3); in_valid = 1;
        @(negedge clk); set_rec(0, 0, 1, 0, 3'b010, 4);
        @(negedge clk); in_valid = 0; chk("trst_busy_before", busy, 1);
        #2 rst = 1'b1;
        #1;
        chk("trst_in_ready", in_ready, 1);
        chk("trst_busy", busy, 0);
        chk("trst_xer_we", xer_we, 0);
        chk("trst_cr_we", cr_we, 0);
        chk("trst_xer_wd", xer_wd, 0);
        chk("trst_cr_wd", cr_wd, 0);
        @(negedge clk); rst = 1'b0; wb_en = 1;
        count_wr(5, n);
        chk("trst_no_writes", n, 0);

        // fill to DEPTH with writeback stalled, then drain in order
        set_arch(32'h0, 32'hFFFF_FFFF);
        wb_en = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); set_rec(1, i[0], 1, 1, 3'(i + 1), 3'(i)); in_valid = 1;
        end
        @(negedge clk); set_rec(1, 1, 1, 1, 3'b111, 4); chk("t4_full_ready", in_ready, 0);
        @(negedge clk); chk("t4_hold_ready", in_ready, 0); in_valid = 0; wb_en = 1;
        count_wr(8, n);
        chk("t4_commits", n, 4);
        chk("t4_busy_end", busy, 0);

        // flush: registered head still commits, queue and same-cycle push are dropped
        idle(4);
        set_arch(32'h0, 32'h0);
        wb_en = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); set_rec(0, 0, 1, 0, 3'b100, 3'(5 + i)); in_valid = 1;
        end
        @(negedge clk); in_valid = 0; wb_en = 1;
        @(negedge clk); flush = 1; set_rec(0, 0, 1, 0, 3'b001, 1); in_valid = 1;
        chk("t5_head_commit", cr_we, 1);
        chk("t5_head_cr_wd", cr_wd, 32'h0010_0000);
        @(negedge clk); flush = 0; in_valid = 0;
        chk("t5_ready", in_ready, 1);
        chk("t5_busy", busy, 0);
        count_wr(5, n);
        chk("t5_no_writes", n, 0);

        // highest CR field, and op code 3 behaving as NOP
        idle(4);
        set_arch(32'h0, 32'h0);
        @(negedge clk); set_rec(3, 1, 1, 1, 3'b111, 7); in_valid = 1;
        @(negedge clk); in_valid = 0;
        @(negedge clk);
        chk("t6_xer_we", xer_we, 0);
        chk("t6_cr_we", cr_we, 1);
        chk("t6_cr_wd", cr_wd, 32'h7000_0000);

        // CR_FIELDS=4 instance: out-of-range field never writes
        idle(2);
        @(negedge clk); set_rec(0, 0, 1, 0, 3'b111, 5); in_valid1 = 1;
        @(negedge clk); in_valid1 = 0;
        n = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (cr_we1) n++;
        end
        chk("t6b_oob_cr_we", n, 0);
        chk("t6b_busy", busy1, 0);
        chk("t6b_ready", in_ready1, 1);
        @(negedge clk); set_rec(0, 0, 1, 0, 3'b100, 3); in_valid1 = 1;
        @(negedge clk); in_valid1 = 0;
        @(negedge clk);
        chk("t6b_cr_we", cr_we1, 1);
        chk("t6b_cr_wd", cr_wd1, 16'h1000);
        chk("t6b_xer_we", xer_we1, 0);
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
